// File: rtl/add_seq_ctrl.sv
// Multi-word adder sequencer: feeds one N-bit slice per cycle (LSW first) through an external
// combinational adder, chaining carries, with valid/ready handshakes on operands and result.
module add_seq_ctrl #(
    parameter int unsigned N     = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a_in,
    input  logic [N*WORDS-1:0] b_in,
    input  logic               cin_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic [N-1:0]       add_x,
    output logic [N-1:0]       add_y,
    output logic               add_cin,
    input  logic [N-1:0]       add_z,
    input  logic               add_cout
);

    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                    state_q, state_d;
    logic [WORDS-1:0][N-1:0]   a_q, a_d;
    logic [WORDS-1:0][N-1:0]   b_q, b_d;
    logic [WORDS-1:0][N-1:0]   sum_q, sum_d;
    logic                      carry_q, carry_d;
    logic [IdxW-1:0]           idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_x     = '0;
        add_y     = '0;
        add_cin   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                add_x        = a_q[idx_q];
                add_y        = b_q[idx_q];
                add_cin      = carry_q;
                sum_d[idx_q] = add_z;
                carry_d      = add_cout;
                if (idx_q == IdxW'(WORDS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sum  = sum_q;
    assign cout = carry_q;

endmodule
